// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS generator/checker pair.
package prbs_pkg;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } prbs_state_e;

    // Default feedback masks; bit i-1 set selects history position i.
    localparam logic [2:0]  TAPS_N3  = 3'b110;
    localparam logic [3:0]  TAPS_N4  = 4'b1100;
    localparam logic [4:0]  TAPS_N5  = 5'b10100;
    localparam logic [5:0]  TAPS_N6  = 6'b110000;
    localparam logic [6:0]  TAPS_N7  = 7'b1100000;
    localparam logic [7:0]  TAPS_N8  = 8'hB8;
    localparam logic [15:0] TAPS_N16 = 16'hB400;
    localparam logic [30:0] TAPS_N31 = 31'h4800_0000;

    function automatic logic prbs_fb(input logic [31:0] hist, input logic [31:0] mask);
        return ^(hist & mask);
    endfunction

endpackage

// File: rtl/prbs_chk_win.sv
// Loss-of-lock window: counts locked bits and errors per 2^WIN_LOG2-bit window,
// strobing loss when the error count within a window reaches LOSS_THRESH.
module prbs_chk_win #(
    parameter int WIN_LOG2    = 6,
    parameter int LOSS_THRESH = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic bit_en,
    input  logic err,
    output logic loss
);

    logic [WIN_LOG2-1:0] win_bits;
    logic [15:0]         win_err;
    logic [15:0]         err_inc;

    assign err_inc = win_err + 16'(err);
    assign loss    = bit_en && err && (err_inc >= 16'(LOSS_THRESH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_bits <= '0;
            win_err  <= '0;
        end else if (bit_en) begin
            if (loss) begin
                win_bits <= '0;
                win_err  <= '0;
            end else begin
                win_bits <= win_bits + WIN_LOG2'(1);
                // The last bit of a window still counts, then the window restarts.
                win_err  <= (&win_bits) ? '0 : err_inc;
            end
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronising LFSR, lock detection and error counting.
// Optional bit_count port is enabled by defining PRBS_CHK_BITCNT_EN.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int             N           = 8,
    parameter logic [N-1:0]   TAP_MASK    = N'(TAPS_N8),
    parameter int             LOCK_CNT    = 16,
    parameter int             WIN_LOG2    = 6,
    parameter int             LOSS_THRESH = 8,
    parameter int             ERR_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
`ifdef PRBS_CHK_BITCNT_EN
    ,
    output logic [31:0]      bit_count
`endif
);

    // in_valid qualifies in_bit each cycle; there is no backpressure, and cycles
    // with in_valid low leave every state element untouched except clear_err effects.

    prbs_state_e  state, state_next;
    logic [N-1:0] h, h_next;
    logic [7:0]   fill_cnt, fill_next;
    logic [7:0]   match_cnt, match_next;
    logic         pred;
    logic         lock_bit;
    logic         lock_err;
    logic         loss;

    assign pred     = prbs_fb(32'(h), 32'(TAP_MASK));
    assign lock_bit = in_valid && (state == ST_LOCKED);
    assign lock_err = lock_bit && (in_bit != pred);

    prbs_chk_win #(
        .WIN_LOG2    (WIN_LOG2),
        .LOSS_THRESH (LOSS_THRESH)
    ) u_win (
        .clk     (clk),
        .reset_n (reset_n),
        .bit_en  (lock_bit),
        .err     (lock_err),
        .loss    (loss)
    );

    always_comb begin
        state_next = state;
        h_next     = h;
        fill_next  = fill_cnt;
        match_next = match_cnt;
        if (in_valid) begin
            case (state)
                ST_FILL: begin
                    h_next = {h[N-2:0], in_bit};
                    if (fill_cnt == 8'(N - 1)) begin
                        state_next = ST_HUNT;
                        fill_next  = '0;
                        match_next = '0;
                    end else begin
                        fill_next = fill_cnt + 8'd1;
                    end
                end
                ST_HUNT: begin
                    h_next = {h[N-2:0], in_bit};
                    // An all-zero history predicts zero forever; never lock on it.
                    if ((in_bit == pred) && (h != '0)) begin
                        if (match_cnt + 8'd1 == 8'(LOCK_CNT)) begin
                            state_next = ST_LOCKED;
                            match_next = '0;
                        end else begin
                            match_next = match_cnt + 8'd1;
                        end
                    end else begin
                        match_next = '0;
                    end
                end
                ST_LOCKED: begin
                    // Free-run on the prediction so a bad bit cannot corrupt later ones.
                    h_next = {h[N-2:0], pred};
                    if (loss) begin
                        state_next = ST_FILL;
                        fill_next  = '0;
                        match_next = '0;
                    end
                end
                default: state_next = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_FILL;
            h         <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_next;
            h         <= h_next;
            fill_cnt  <= fill_next;
            match_cnt <= match_next;
            locked    <= (state_next == ST_LOCKED);
            err_pulse <= lock_err;
            if (clear_err) begin
                err_count <= lock_err ? ERR_W'(1) : '0;
            end else if (lock_err && !(&err_count)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

`ifdef PRBS_CHK_BITCNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_count <= '0;
        end else if (clear_err) begin
            bit_count <= lock_bit ? 32'd1 : 32'd0;
        end else if (lock_bit && !(&bit_count)) begin
            bit_count <= bit_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: instance A (N=3, LOCK_CNT=4) and instance B (N=8, ERR_W=4, LOSS_THRESH=255).
module tb_prbs_checker;

    localparam int         AN    = 3;
    localparam logic [2:0] AMASK = 3'b110;
    localparam logic [7:0] BMASK = 8'hB8;

    typedef struct packed {
        logic        v;
        logic        b;
        logic        clr;
        logic        el;
        logic        ep;
        logic [15:0] ec;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic a_valid = 1'b0, a_bit = 1'b0, a_clr = 1'b0;
    logic b_valid = 1'b0, b_bit = 1'b0, b_clr = 1'b0;
    logic        a_locked, a_pulse;
    logic [15:0] a_cnt;
    logic        b_locked, b_pulse;
    logic [3:0]  b_cnt;
`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0] a_bits, b_bits;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [17:0] exp_q[$];
    logic [31:0] ga, gb;
    vec_t        tbl[9];

    always #5 clk = ~clk;

    prbs_checker #(
        .N (AN), .TAP_MASK (AMASK), .LOCK_CNT (4)
    ) dut_a (
        .clk (clk), .reset_n (reset_n), .in_valid (a_valid), .in_bit (a_bit),
        .clear_err (a_clr), .locked (a_locked), .err_pulse (a_pulse), .err_count (a_cnt)
`ifdef PRBS_CHK_BITCNT_EN
        , .bit_count (a_bits)
`endif
    );

    prbs_checker #(
        .N (8), .TAP_MASK (BMASK), .LOCK_CNT (16), .LOSS_THRESH (255), .ERR_W (4)
    ) dut_b (
        .clk (clk), .reset_n (reset_n), .in_valid (b_valid), .in_bit (b_bit),
        .clear_err (b_clr), .locked (b_locked), .err_pulse (b_pulse), .err_count (b_cnt)
`ifdef PRBS_CHK_BITCNT_EN
        , .bit_count (b_bits)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic next_a(output logic b);
        b  = ^(ga & 32'(AMASK));
        ga = {ga[30:0], b};
    endtask

    task automatic next_b(output logic b);
        b  = ^(gb & 32'(BMASK));
        gb = {gb[30:0], b};
    endtask

    // Drive one cycle on instance sel, queue its expected {locked, err_pulse, err_count}.
    task automatic step(input bit sel, input logic v, input logic bi, input logic clr,
                        input logic el, input logic ep, input logic [15:0] ec, input string name);
        logic [17:0] exp, got;
        if (!sel) begin
            a_valid = v; a_bit = bi; a_clr = clr; b_valid = 1'b0; b_clr = 1'b0;
        end else begin
            b_valid = v; b_bit = bi; b_clr = clr; a_valid = 1'b0; a_clr = 1'b0;
        end
        exp_q.push_back({el, ep, ec});
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        got = sel ? {b_locked, b_pulse, 12'd0, b_cnt} : {a_locked, a_pulse, a_cnt};
        check(name, 32'(got), 32'(exp));
    endtask

    task automatic do_reset(input string name);
        a_valid = 1'b0; a_clr = 1'b0; b_valid = 1'b0; b_clr = 1'b0;
        reset_n = 1'b0;
        #2;
        check({name, "_a"}, {13'd0, a_locked, a_pulse, a_cnt}, 32'd0);
        check({name, "_b"}, {25'd0, b_locked, b_pulse, b_cnt}, 32'd0);
`ifdef PRBS_CHK_BITCNT_EN
        check({name, "_bitcnt"}, a_bits | b_bits, 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic bit_v;
        int   a_lb;
        int   vcnt;

        // Clean N=3 stream 0,1,0,1,1,1,0 with two idle cycles mixed in.
        tbl[0] = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1] = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[2] = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[3] = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[4] = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[5] = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[6] = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[7] = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[8] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};

        #12;
        do_reset("reset_init");

        for (int i = 0; i < 9; i++)
            step(0, tbl[i].v, tbl[i].b, tbl[i].clr, tbl[i].el, tbl[i].ep, tbl[i].ec, "a_table");
        ga   = 32'h6;
        a_lb = 0;

        for (int i = 0; i < 1000; i++) begin
            next_a(bit_v);
            step(0, 1'b1, bit_v, 1'b0, 1'b1, 1'b0, 16'd0, "a_clean1000");
            a_lb++;
        end

        next_a(bit_v);
        step(0, 1'b1, ~bit_v, 1'b0, 1'b1, 1'b1, 16'd1, "a_single_err");
        a_lb++;
        for (int i = 0; i < 20; i++) begin
            next_a(bit_v);
            step(0, 1'b1, bit_v, 1'b0, 1'b1, 1'b0, 16'd1, "a_after_err");
            a_lb++;
        end

        step(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, "a_clear_idle");

        // Align to a window start so the burst lands in a single window.
        while (a_lb % 64 != 0) begin
            next_a(bit_v);
            step(0, 1'b1, bit_v, 1'b0, 1'b1, 1'b0, 16'd0, "a_pad");
            a_lb++;
        end
        for (int k = 1; k <= 8; k++) begin
            next_a(bit_v);
            step(0, 1'b1, ~bit_v, 1'b0, (k < 8), 1'b1, 16'(k), "a_burst");
        end
        for (int k = 1; k <= 7; k++) begin
            next_a(bit_v);
            step(0, 1'b1, bit_v, 1'b0, (k == 7), 1'b0, 16'd8, "a_relock");
        end

        do_reset("reset_midlock");
        for (int i = 0; i < 500; i++)
            step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, "a_zeros");

        do_reset("reset_gap");
        ga   = 32'h6;
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                next_a(bit_v);
                vcnt++;
                step(0, 1'b1, bit_v, 1'b0, (vcnt >= 7), 1'b0, 16'd0, "a_gap_valid");
            end else begin
                step(0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, (vcnt >= 7), 1'b0, 16'd0, "a_gap_idle");
            end
        end

        do_reset("reset_relock");
        ga = 32'h6;
        for (int k = 1; k <= 7; k++) begin
            next_a(bit_v);
            step(0, 1'b1, bit_v, 1'b0, (k == 7), 1'b0, 16'd0, "a_post_reset");
        end

        gb = 32'h1;
        for (int k = 1; k <= 24; k++) begin
            next_b(bit_v);
            step(1, 1'b1, bit_v, 1'b0, (k == 24), 1'b0, 16'd0, "b_lock");
        end
        for (int k = 1; k <= 20; k++) begin
            next_b(bit_v);
            step(1, 1'b1, ~bit_v, 1'b0, 1'b1, 1'b1, (k < 15) ? 16'(k) : 16'd15, "b_saturate");
        end
        next_b(bit_v);
        step(1, 1'b1, ~bit_v, 1'b1, 1'b1, 1'b1, 16'd1, "b_clear_with_err");
        next_b(bit_v);
        step(1, 1'b1, bit_v, 1'b1, 1'b1, 1'b0, 16'd0, "b_clear_clean");
        next_b(bit_v);
        step(1, 1'b1, ~bit_v, 1'b0, 1'b1, 1'b1, 16'd1, "b_err_after_clear");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
